uart_receiver: RTL and testbench
================================

# uart_receiver

Serial UART receiver for the Atlys top level: turns the asynchronous line on UART_RX into bytes for on-chip logic. Recovers 8N1 frames (optionally 8E1) at a fixed baud derived from CLK, and presents each byte on a valid/ready handshake. Flags framing errors, parity errors and overrun. It is the receiving counterpart of the design's UART transmit path and sits directly between the UART_RX pin net and user logic.

## Interface
- CLKS_PER_BIT, 868, CLK cycles per bit; 868 gives 115200 baud at 100 MHz; minimum 4; HALF = CLKS_PER_BIT >> 1.
- CLK  in  1  master clock, all logic on rising edge.
- reset_trigger  in  1  reset, asynchronous, active-high.
- UART_RX  in  1  raw serial line, idle high, asynchronous to CLK.
- rx_data  out  8  received byte, stable while rx_valid is high.
- rx_valid  out  1  byte available; held until accepted.
- rx_ready  in  1  consumer accepts the byte on any CLK edge where rx_valid && rx_ready.
- busy  out  1  high from start-bit detection until the frame ends (good stop or error).
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- parity_err  out  1  one-cycle pulse: parity mismatch; tied 0 when parity is not compiled in.
- overrun  out  1  one-cycle pulse: completed byte dropped because the holding register was full.

## Operation
- UART_RX passes through a 2-flop synchronizer. Both flops reset to 1. The synchronized signal is rx_s.
- States: WAIT_IDLE, IDLE, START, DATA, PARITY (only with macro), STOP, BREAK.
- WAIT_IDLE is the reset state. Move to IDLE on the first cycle rx_s = 1. This prevents false starts when reset releases mid-frame.
- IDLE: on rx_s = 0, go to START, clear the bit counter and assert busy.
- START: count HALF cycles, then sample rx_s. If rx_s = 0, go to DATA. If rx_s = 1, treat it as a glitch: return to IDLE and clear busy. No flags are raised.
- DATA: sample every CLKS_PER_BIT cycles, LSB first, into a shift register. After 8 samples, go to PARITY or STOP.
- PARITY: sample one bit. Even parity: the XOR of 8 data bits and the parity bit must be 0.
- STOP: sample after CLKS_PER_BIT cycles.
  - Sample 1 with no parity error: commit the byte and return to IDLE immediately, at the middle of the stop bit.
  - Sample 1 with a parity error: pulse parity_err, discard the byte, go to IDLE.
  - Sample 0: pulse frame_err, discard the byte, go to BREAK.
- BREAK: wait for rx_s = 1, then go to IDLE. busy stays high throughout BREAK.
- Commit rules:
  - If rx_valid = 0, or rx_ready = 1 in the commit cycle, load rx_data and set rx_valid = 1.
  - Otherwise pulse overrun, drop the new byte and keep the old one.
  - Accept without a simultaneous commit clears rx_valid.
- Counters must be wide enough for CLKS_PER_BIT - 1 (use $clog2). The bit counter is 3 bits plus a done condition; no wrap artefacts.

## Timing
- Reset values: rx_data = 0x00; rx_valid = 0; busy = 0; frame_err = 0; parity_err = 0; overrun = 0; state WAIT_IDLE.
- Reset asserted mid-frame aborts immediately; the partial byte is lost.
- Let t0 be the CLK edge at which the first sync flop captures 0. Then:
  - busy is high from edge t0 + 2.
  - rx_valid is high from edge t0 + 3 + HALF + 9·CLKS_PER_BIT (8N1), or + 10·CLKS_PER_BIT (8E1).
- Error pulses occur at the same edge the commit would have occurred.
- Back-to-back frames with no idle gap are received without loss, provided the consumer accepts within 1 frame time.
- Tolerance: sampling at mid-bit tolerates ±4% total baud mismatch (8N1).

## Configuration
- UART_RX_PARITY_EN defined: 8E1 frames, the PARITY state exists, and parity_err is driven.
- UART_RX_PARITY_EN undefined: 8N1 frames, no PARITY state, and parity_err is constant 0.

## Test plan
- All cases use CLKS_PER_BIT = 8. Send 0xA5 in 8N1 with rx_ready = 0 -> rx_data = 0xA5, rx_valid high at t0 + 79 and held; pulse rx_ready -> rx_valid low the next cycle.
- UART_RX low for 2 cycles, then high -> busy drops after the start check; no rx_valid; no flags.
- Send 0x3C with stop bit 0, hold the line low for 20 bit times, then send 0x81 -> one frame_err pulse, no valid for 0x3C; busy stays high until the line returns high; 0x81 is then received correctly.
- Send 0x11 then 0x22 back-to-back with rx_ready = 0 -> rx_data stays 0x11 and one overrun pulse occurs. Repeat with rx_ready = 1 only in the 0x22 commit cycle -> rx_data = 0x22, rx_valid stays high, no overrun.
- Assert reset_trigger during data bit 4 and release while the line is low -> all outputs 0 and no reception until the line goes high; a following 0x5A is received correctly.
- With UART_RX_PARITY_EN defined: send 0x07 with parity bit 1 -> accepted. Send 0x07 with parity bit 0 -> parity_err pulse, rx_valid stays 0.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receiver: 8N1 frames by default, 8E1 when UART_RX_PARITY_EN is defined.
// Each bit is sampled once per bit time; errors are reported as one-cycle pulses.
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       reset_trigger,
    input  logic       UART_RX,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam int unsigned HALF = CLKS_PER_BIT >> 1;
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntHalf = CntW'(HALF);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] StWaitIdle = 3'd0;
    localparam logic [2:0] StIdle     = 3'd1;
    localparam logic [2:0] StStart    = 3'd2;
    localparam logic [2:0] StData     = 3'd3;
    localparam logic [2:0] StStop     = 3'd4;
    localparam logic [2:0] StBreak    = 3'd5;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] StParity   = 3'd6;
`endif

    logic            rx_meta_q, rx_meta_d;
    logic            rx_s_q, rx_s_d;
    logic [1:0]      fill_q, fill_d;
    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            busy_q, busy_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            commit;
    logic            cnt_last;
`ifdef UART_RX_PARITY_EN
    logic            par_bad_q, par_bad_d;
    logic            parity_err_q, parity_err_d;
`endif

    assign cnt_last = (cnt_q == CntLast);

    always_comb begin
        rx_meta_d   = UART_RX;
        rx_s_d      = rx_meta_q;
        // The synchronizer resets to 1; only trust rx_s once it holds real line samples.
        fill_d      = {fill_q[0], 1'b1};
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        busy_d      = busy_q;
        frame_err_d = 1'b0;
        commit      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            StWaitIdle: begin
                if (fill_q[1] && rx_s_q) state_d = StIdle;
            end
            StIdle: begin
                if (!rx_s_q) begin
                    state_d   = StStart;
                    cnt_d     = '0;
                    bit_cnt_d = 3'd0;
                    busy_d    = 1'b1;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = StData;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_last) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_last) begin
                    cnt_d     = '0;
                    par_bad_d = ^{shift_q, rx_s_q};
                    state_d   = StStop;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
`endif
            StStop: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end else begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_q) parity_err_d = 1'b1;
                        else           commit       = 1'b1;
`else
                        commit = 1'b1;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StBreak: begin
                if (rx_s_q) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = StWaitIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Holding register: a commit may replace a byte only when it is accepted in the same cycle.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
        if (commit) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge reset_trigger) begin
        if (reset_trigger) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            fill_q      <= 2'b00;
            state_q     <= StWaitIdle;
            cnt_q       <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            busy_q      <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            fill_q      <= fill_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            busy_q      <= busy_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge CLK or posedge reset_trigger) begin
        if (reset_trigger) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at CLKS_PER_BIT = 8: vector table, directed corner cases and a
// randomized frame stream checked against a byte-queue model.
module tb_uart_receiver;

    localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME = (10 + PBITS) * CPB;

    logic       CLK = 1'b0;
    logic       reset_trigger;
    logic       UART_RX;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    always #5 CLK = ~CLK;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .CLK           (CLK),
        .reset_trigger (reset_trigger),
        .UART_RX       (UART_RX),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .busy          (busy),
        .frame_err     (frame_err),
        .parity_err    (parity_err),
        .overrun       (overrun)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;
    int ov_cnt = 0;
    logic [7:0] acc_q[$];
    logic [7:0] exp_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (frame_err)  fe_cnt <= fe_cnt + 1;
        if (parity_err) pe_cnt <= pe_cnt + 1;
        if (overrun)    ov_cnt <= ov_cnt + 1;
        if (rx_valid && rx_ready) acc_q.push_back(rx_data);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick(1);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rx_data"}, 32'(rx_data), 32'h00);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
        check({tag, "_parity_err"}, 32'(parity_err), 32'h0);
        check({tag, "_overrun"}, 32'(overrun), 32'h0);
    endtask

    // Drives one frame; returns at the end of the stop bit with the line left at 'stop'.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
        UART_RX = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        UART_RX = (^b) ^ par_flip;
        tick(CPB);
`endif
        UART_RX = stop;
        tick(CPB);
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_fe;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    int k, k1, fe0, pe0, ov0, exp_fe, exp_pe, gap, n_cmp;
    logic [7:0] rb;
    logic rstop, rflip;

    initial begin
        vecs[0] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h00, exp_fe: 0};
        vecs[1] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hFF, exp_fe: 0};
        vecs[2] = '{data: 8'h55, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h55, exp_fe: 0};
        vecs[3] = '{data: 8'h80, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h80, exp_fe: 0};
        vecs[4] = '{data: 8'h3C, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_fe: 1};
        vecs[5] = '{data: 8'h01, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h01, exp_fe: 0};

        reset_trigger = 1'b1;
        UART_RX       = 1'b1;
        rx_ready      = 1'b0;
        tick(3);
        check_zero("reset_held");
        reset_trigger = 1'b0;
        tick(5);
        check_zero("after_reset");

        // 0xA5 with exact busy / rx_valid timing.
        k = cyc;
        fork
            begin
                send_frame(8'hA5, 1'b1, 1'b0);
                UART_RX = 1'b1;
            end
            begin
                wait_cyc(k + 2);
                check("a5_busy_early", 32'(busy), 32'h0);
                wait_cyc(k + 3);
                check("a5_busy_on", 32'(busy), 32'h1);
                wait_cyc(k + FRAME - 1);
                check("a5_valid_early", 32'(rx_valid), 32'h0);
                wait_cyc(k + FRAME);
                check("a5_valid_on", 32'(rx_valid), 32'h1);
            end
        join
        tick(3 * CPB);
        check("a5_valid_held", 32'(rx_valid), 32'h1);
        check("a5_data", 32'(rx_data), 32'hA5);
        accept();
        check("a5_valid_cleared", 32'(rx_valid), 32'h0);

        // Start-bit glitch.
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
        k = cyc;
        UART_RX = 1'b0;
        tick(2);
        UART_RX = 1'b1;
        wait_cyc(k + 3);
        check("glitch_busy_on", 32'(busy), 32'h1);
        wait_cyc(k + 8);
        check("glitch_busy_off", 32'(busy), 32'h0);
        tick(FRAME);
        check("glitch_no_valid", 32'(rx_valid), 32'h0);
        check("glitch_no_flags", 32'((fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0)), 32'h0);

        // Vector table.
        for (int i = 0; i < NV; i++) begin
            fe0 = fe_cnt;
            send_frame(vecs[i].data, vecs[i].stop, 1'b0);
            UART_RX = 1'b1;
            tick(2 * CPB);
            check($sformatf("tbl%0d_valid", i), 32'(rx_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("tbl%0d_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
                accept();
            end
            check($sformatf("tbl%0d_fe", i), 32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
        end

        // Stop bit low followed by a long break, then a good frame.
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        tick(19 * CPB);
        check("break_busy", 32'(busy), 32'h1);
        check("break_no_valid", 32'(rx_valid), 32'h0);
        check("break_fe_once", 32'(fe_cnt - fe0), 32'h1);
        UART_RX = 1'b1;
        tick(4);
        check("break_busy_off", 32'(busy), 32'h0);
        tick(CPB);
        send_frame(8'h81, 1'b1, 1'b0);
        UART_RX = 1'b1;
        tick(CPB);
        check("break_next_valid", 32'(rx_valid), 32'h1);
        check("break_next_data", 32'(rx_data), 32'h81);
        accept();

        // Back-to-back frames with the holding register full.
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        UART_RX = 1'b1;
        tick(CPB);
        check("ovr_data_kept", 32'(rx_data), 32'h11);
        check("ovr_valid", 32'(rx_valid), 32'h1);
        check("ovr_pulse", 32'(ov_cnt - ov0), 32'h1);
        accept();

        // Same pair, accepted exactly in the second commit cycle.
        ov0 = ov_cnt;
        k1 = cyc;
        fork
            begin
                send_frame(8'h11, 1'b1, 1'b0);
                send_frame(8'h22, 1'b1, 1'b0);
                UART_RX = 1'b1;
            end
            begin
                wait_cyc(k1 + 2 * FRAME - 1);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
            end
        join
        tick(CPB);
        check("swap_data", 32'(rx_data), 32'h22);
        check("swap_valid", 32'(rx_valid), 32'h1);
        check("swap_no_ovr", 32'(ov_cnt - ov0), 32'h0);
        accept();

        // Reset during data bit 4, released while the line is still low.
        fe0 = fe_cnt;
        k = cyc;
        fork
            begin
                send_frame(8'h00, 1'b1, 1'b0);
                UART_RX = 1'b1;
            end
            begin
                wait_cyc(k + 42);
                reset_trigger = 1'b1;
                #1;
                check("rst_mid_busy", 32'(busy), 32'h0);
                wait_cyc(k + 45);
                reset_trigger = 1'b0;
                wait_cyc(k + 46);
                check_zero("rst_release");
                wait_cyc(k + 70);
                check("rst_no_false_start", 32'(busy), 32'h0);
            end
        join
        tick(2 * CPB);
        check("rst_no_valid", 32'(rx_valid), 32'h0);
        check("rst_no_fe", 32'(fe_cnt - fe0), 32'h0);
        send_frame(8'h5A, 1'b1, 1'b0);
        UART_RX = 1'b1;
        tick(CPB);
        check("rst_next_valid", 32'(rx_valid), 32'h1);
        check("rst_next_data", 32'(rx_data), 32'h5A);
        accept();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        UART_RX = 1'b1;
        tick(CPB);
        check("par_good_valid", 32'(rx_valid), 32'h1);
        check("par_good_data", 32'(rx_data), 32'h07);
        accept();
        pe0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        UART_RX = 1'b1;
        tick(CPB);
        check("par_bad_pulse", 32'(pe_cnt - pe0), 32'h1);
        check("par_bad_no_valid", 32'(rx_valid), 32'h0);
`endif

        // Random stream with an always-ready consumer.
        tick(CPB);
        acc_q.delete();
        exp_q.delete();
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
        exp_fe = 0; exp_pe = 0;
        rx_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
            rflip = ($urandom_range(0, 4) == 0);
`else
            rflip = 1'b0;
`endif
            if (!rstop)          exp_fe++;
            else if (rflip)      exp_pe++;
            else                 exp_q.push_back(rb);
            send_frame(rb, rstop, rflip);
            UART_RX = 1'b1;
            gap = rstop ? int'($urandom_range(0, 2 * CPB)) : int'($urandom_range(CPB, 2 * CPB));
            tick(gap);
        end
        tick(3 * CPB);
        rx_ready = 1'b0;
        check("rnd_count", 32'(acc_q.size()), 32'(exp_q.size()));
        n_cmp = (acc_q.size() < exp_q.size()) ? acc_q.size() : exp_q.size();
        for (int i = 0; i < n_cmp; i++)
            check($sformatf("rnd_byte%0d", i), 32'(acc_q[i]), 32'(exp_q[i]));
        check("rnd_fe", 32'(fe_cnt - fe0), 32'(exp_fe));
        check("rnd_pe", 32'(pe_cnt - pe0), 32'(exp_pe));
        check("rnd_ovr", 32'(ov_cnt - ov0), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
